// File: rtl/execute_multicycle.sv
// Execute stage: single-cycle ADD/SUB/logic/MUL with a ready/valid output register.
// Define EXEC_ITER_DIV_EN to build the iterative restoring DIV/MOD unit; otherwise DIV/MOD return 0 with V set.
module execute_multicycle #(
    parameter int W    = 32,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            v_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [W-1:0]    opr0_i,
    input  logic [W-1:0]    opr1_i,
    input  logic [2:0]      op_i,
    input  logic            signed_i,
    input  logic [W_RD-1:0] wb_r_i,
    input  logic            wb_en_i,
    output logic            v_o,
    output logic            stall_o,
    output logic [W-1:0]    result_o,
    output logic [3:0]      flags_o,
    output logic [W_RD-1:0] wb_r_o,
    output logic            wb_o
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

    logic           load_en;
    logic           accept;
    logic           is_divmod;
    logic           wb_en_reg;
    logic [W-1:0]   alu_res;
    logic           alu_c;
    logic           alu_v;
    logic [3:0]     alu_flags;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] prod;

    assign load_en   = ~stall_i | ~v_o;
    assign accept    = v_i & ~stall_o & ~flush_i;
    assign is_divmod = (op_i == OP_DIV) | (op_i == OP_MOD);
    assign wb_o      = v_o & wb_en_reg;

    // Extending both operands to 2W makes the low 2W product bits correct for signed and unsigned alike
    assign ext_a = {{W{signed_i & opr0_i[W-1]}}, opr0_i};
    assign ext_b = {{W{signed_i & opr1_i[W-1]}}, opr1_i};
    assign prod  = ext_a * ext_b;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, opr0_i} + {1'b0, opr1_i};
                alu_v = (opr0_i[W-1] == opr1_i[W-1]) & (alu_res[W-1] != opr0_i[W-1]);
            end
            OP_SUB: begin
                {alu_c, alu_res} = {1'b0, opr0_i} - {1'b0, opr1_i};
                alu_v = (opr0_i[W-1] != opr1_i[W-1]) & (alu_res[W-1] != opr0_i[W-1]);
            end
            OP_AND: alu_res = opr0_i & opr1_i;
            OP_OR:  alu_res = opr0_i | opr1_i;
            OP_XOR: alu_res = opr0_i ^ opr1_i;
            OP_MUL: begin
                alu_res = prod[W-1:0];
                alu_v   = signed_i ? (prod[2*W-1:W] != {W{prod[W-1]}})
                                   : (prod[2*W-1:W] != '0);
            end
            default: begin
`ifdef EXEC_ITER_DIV_EN
                // Only taken for a zero divisor; nonzero divisors go through the FSM
                alu_res = (op_i == OP_DIV) ? '1 : opr0_i;
`else
                alu_res = '0;
`endif
                alu_v = 1'b1;
            end
        endcase
        alu_flags = {alu_v, alu_res[W-1], alu_res == '0, alu_c};
    end

`ifdef EXEC_ITER_DIV_EN
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;
    logic [W-1:0]    dvs;
    logic            neg_q;
    logic            neg_r;
    logic            ovf_pend;
    logic            mod_pend;
    logic [W_RD-1:0] wb_r_pend;
    logic            wb_en_pend;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [W:0]      rem_shift;
    logic            fits;
    logic [W-1:0]    rem_next;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;
    logic [W-1:0]    div_res;
    logic [3:0]      div_flags;

    assign div_zero = (opr1_i == '0);
    assign div_ovf  = signed_i & (opr0_i == {1'b1, {(W-1){1'b0}}}) & (opr1_i == '1);
    assign mag_a    = (signed_i & opr0_i[W-1]) ? -opr0_i : opr0_i;
    assign mag_b    = (signed_i & opr1_i[W-1]) ? -opr1_i : opr1_i;

    // Dividend shifts out of quo into rem while quotient bits shift into quo
    assign rem_shift = {rem, quo[W-1]};
    assign fits      = rem_shift >= {1'b0, dvs};
    assign rem_next  = fits ? W'(rem_shift - {1'b0, dvs}) : rem_shift[W-1:0];

    assign q_fix     = neg_q ? -quo : quo;
    assign r_fix     = neg_r ? -rem : rem;
    assign div_res   = mod_pend ? r_fix : q_fix;
    assign div_flags = {ovf_pend, div_res[W-1], div_res == '0, 1'b0};

    assign stall_o = ~load_en | (state != IDLE);
`else
    assign stall_o = ~load_en;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_o       <= 1'b0;
            result_o  <= '0;
            flags_o   <= '0;
            wb_r_o    <= '0;
            wb_en_reg <= 1'b0;
`ifdef EXEC_ITER_DIV_EN
            state      <= IDLE;
            cnt        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            ovf_pend   <= 1'b0;
            mod_pend   <= 1'b0;
            wb_r_pend  <= '0;
            wb_en_pend <= 1'b0;
`endif
        end else if (flush_i) begin
            v_o <= 1'b0;
`ifdef EXEC_ITER_DIV_EN
            state <= IDLE;
            cnt   <= '0;
`endif
        end else begin
`ifdef EXEC_ITER_DIV_EN
            case (state)
                IDLE: begin
                    if (accept && is_divmod && !div_zero) begin
                        // Output register keeps its previous contents until the quotient is ready
                        quo        <= mag_a;
                        rem        <= '0;
                        dvs        <= mag_b;
                        neg_q      <= signed_i & (opr0_i[W-1] ^ opr1_i[W-1]);
                        neg_r      <= signed_i & opr0_i[W-1];
                        ovf_pend   <= div_ovf;
                        mod_pend   <= (op_i == OP_MOD);
                        wb_r_pend  <= wb_r_i;
                        wb_en_pend <= wb_en_i;
                        cnt        <= CW'(W);
                        state      <= BUSY;
                    end else if (accept) begin
                        v_o       <= 1'b1;
                        result_o  <= alu_res;
                        flags_o   <= alu_flags;
                        wb_r_o    <= wb_r_i;
                        wb_en_reg <= wb_en_i;
                    end else if (load_en) begin
                        v_o <= 1'b0;
                    end
                end
                BUSY: begin
                    quo <= {quo[W-2:0], fits};
                    rem <= rem_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                    if (load_en) begin
                        v_o <= 1'b0;
                    end
                end
                FIX: begin
                    if (load_en) begin
                        v_o       <= 1'b1;
                        result_o  <= div_res;
                        flags_o   <= div_flags;
                        wb_r_o    <= wb_r_pend;
                        wb_en_reg <= wb_en_pend;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`else
            if (accept) begin
                v_o       <= 1'b1;
                result_o  <= alu_res;
                flags_o   <= alu_flags;
                wb_r_o    <= wb_r_i;
                wb_en_reg <= wb_en_i;
            end else if (load_en) begin
                v_o <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_execute_multicycle.sv
// Directed bench for execute_multicycle: scoreboard of model results, checked when v_o rises.
// Divider scenarios are exercised when EXEC_ITER_DIV_EN is defined, the stub behaviour otherwise.
module tb_execute_multicycle;
    localparam int W    = 32;
    localparam int W_RD = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            v_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [W-1:0]    opr0_i = '0;
    logic [W-1:0]    opr1_i = '0;
    logic [2:0]      op_i = '0;
    logic            signed_i = 1'b0;
    logic [W_RD-1:0] wb_r_i = '0;
    logic            wb_en_i = 1'b0;
    logic            v_o;
    logic            stall_o;
    logic [W-1:0]    result_o;
    logic [3:0]      flags_o;
    logic [W_RD-1:0] wb_r_o;
    logic            wb_o;

    typedef struct {
        logic [W-1:0]    res;
        logic [3:0]      flags;
        logic [W_RD-1:0] rd;
        logic            wb;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    execute_multicycle #(.W(W), .W_RD(W_RD)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .stall_i(stall_i), .flush_i(flush_i),
        .opr0_i(opr0_i), .opr1_i(opr1_i), .op_i(op_i), .signed_i(signed_i),
        .wb_r_i(wb_r_i), .wb_en_i(wb_en_i), .v_o(v_o), .stall_o(stall_o),
        .result_o(result_o), .flags_o(flags_o), .wb_r_o(wb_r_o), .wb_o(wb_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input logic [W_RD-1:0] rd, input logic wben);
        exp_t e;
        logic [W:0] s;
        logic [2*W-1:0] p;
        longint sa, sb, q, rm;
        logic c, v;
        logic [W-1:0] r;
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                if (sgn) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b)); p = sa * sb;
                    v = (p[2*W-1:W] != {W{p[W-1]}});
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                    v = (p[2*W-1:W] != 0);
                end
                r = p[W-1:0];
            end
            default: begin
`ifdef EXEC_ITER_DIV_EN
                if (b == 0) begin
                    r = (op == 3'd6) ? '1 : a; v = 1'b1;
                end else if (sgn) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    q = sa / sb; rm = sa % sb;
                    r = (op == 3'd6) ? q[W-1:0] : rm[W-1:0];
                    v = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end else begin
                    r = (op == 3'd6) ? a / b : a % b;
                end
`else
                r = '0; v = 1'b1;
`endif
            end
        endcase
        e.res = r; e.flags = {v, r[W-1], r == 0, c}; e.rd = rd; e.wb = wben;
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W_RD-1:0] rd, input logic wben, input bit push);
        if (push) sb_q.push_back(model(op, a, b, sgn, rd, wben));
        op_i = op; opr0_i = a; opr1_i = b; signed_i = sgn; wb_r_i = rd; wb_en_i = wben; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat, input int exp_stall);
        int lat = 1;
        int stalls = 0;
        exp_t e;
        while (v_o !== 1'b1 && lat < 100) begin
            if (stall_o === 1'b1) stalls++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stallcyc"}, 64'(stalls), 64'(exp_stall));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_res"}, 64'(result_o), 64'(e.res));
            check({tag, "_flags"}, 64'(flags_o), 64'(e.flags));
            check({tag, "_wbr"}, 64'(wb_r_o), 64'(e.rd));
            check({tag, "_wb"}, 64'(wb_o), 64'(e.wb));
            $display("[TB] %s: result=%h flags=%b wb_r=%0d wb=%b lat=%0d", tag, result_o, flags_o, wb_r_o, wb_o, lat);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_v"}, 64'(v_o), 64'(0));
        check({tag, "_res"}, 64'(result_o), 64'(0));
        check({tag, "_flags"}, 64'(flags_o), 64'(0));
        check({tag, "_wbr"}, 64'(wb_r_o), 64'(0));
        check({tag, "_wb"}, 64'(wb_o), 64'(0));
        check({tag, "_stall"}, 64'(stall_o), 64'(0));
    endtask

    task automatic no_result_for(input string tag, input int n);
        logic any_v = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (v_o === 1'b1) any_v = 1'b1;
        end
        check(tag, 64'(any_v), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t drop;
        #1 reset = 1'b0;
        #1 check_zero_outputs("reset");
        idle(2);
        reset = 1'b1;
        idle(1);

        issue(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd3, 1'b1, 1); collect("add_wrap", 1, 0);
        check("add_wrap_lit", 64'({result_o, flags_o}), 64'({32'h0, 4'b0011}));
        issue(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd4, 1'b0, 1); collect("add_ovf", 1, 0);
        issue(3'd1, 32'd5, 32'd7, 1'b0, 5'd5, 1'b1, 1);          collect("sub_borrow", 1, 0);
        issue(3'd1, 32'h8000_0000, 32'd1, 1'b1, 5'd6, 1'b1, 1);  collect("sub_ovf", 1, 0);
        issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd7, 1'b1, 1); collect("and", 1, 0);
        issue(3'd3, 32'h0F0F_0000, 32'h8000_00F0, 1'b0, 5'd8, 1'b0, 1); collect("or", 1, 0);
        issue(3'd4, 32'h1234_5678, 32'h1234_5678, 1'b0, 5'd9, 1'b1, 1); collect("xor_zero", 1, 0);
        issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5'd10, 1'b1, 1); collect("mulu_ovf", 1, 0);
        issue(3'd5, 32'hFFFF_FFFD, 32'd4, 1'b1, 5'd11, 1'b1, 1); collect("muls_neg", 1, 0);
        issue(3'd5, 32'h0001_0000, 32'h0001_0000, 1'b1, 5'd12, 1'b1, 1); collect("muls_ovf", 1, 0);

        // Output held while downstream stalls; the waiting op enters once the stall drops
        issue(3'd3, 32'h00AA_0000, 32'h0000_0055, 1'b0, 5'd13, 1'b1, 1);
        stall_i = 1'b1;
        op_i = 3'd4; opr0_i = 32'hFFFF_0000; opr1_i = 32'h0F0F_0F0F; signed_i = 1'b0;
        wb_r_i = 5'd14; wb_en_i = 1'b0; v_i = 1'b1;
        #1 check("stall_o_high", 64'(stall_o), 64'(1));
        idle(2);
        check("stall_hold_v", 64'(v_o), 64'(1));
        check("stall_hold_res", 64'(result_o), 64'(sb_q[0].res));
        stall_i = 1'b0;
        sb_q.push_back(model(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 5'd14, 1'b0));
        idle(1);
        v_i = 1'b0;
        drop = sb_q.pop_front();
        collect("after_stall", 1, 0);

        // Flush wins over a simultaneous acceptance
        issue(3'd0, 32'd1, 32'd2, 1'b0, 5'd1, 1'b1, 1); collect("pre_flush", 1, 0);
        op_i = 3'd4; opr0_i = 32'hDEAD_BEEF; opr1_i = 32'h1; v_i = 1'b1; flush_i = 1'b1;
        idle(1);
        v_i = 1'b0; flush_i = 1'b0;
        check("flush_prio_v", 64'(v_o), 64'(0));
        check("flush_prio_res", 64'(result_o), 64'(32'd3));

`ifdef EXEC_ITER_DIV_EN
        idle(1); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd20, 1'b1, 1); collect("sdiv", 34, 33);
        check("sdiv_lit", 64'(result_o), 64'(32'hFFFF_FFFD));
        idle(1); issue(3'd7, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd21, 1'b1, 1); collect("smod", 34, 33);
        check("smod_lit", 64'(result_o), 64'(32'hFFFF_FFFF));
        idle(1); issue(3'd6, 32'd100, 32'd7, 1'b0, 5'd22, 1'b0, 1); collect("udiv", 34, 33);
        idle(1); issue(3'd7, 32'd100, 32'd7, 1'b0, 5'd23, 1'b1, 1); collect("umod", 34, 33);
        idle(1); issue(3'd6, 32'd100, 32'd0, 1'b0, 5'd24, 1'b1, 1); collect("div0", 1, 0);
        check("div0_lit", 64'({result_o, flags_o[3]}), 64'({32'hFFFF_FFFF, 1'b1}));
        idle(1); issue(3'd7, 32'd100, 32'd0, 1'b0, 5'd25, 1'b1, 1); collect("mod0", 1, 0);
        idle(1); issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd26, 1'b1, 1); collect("sdiv_ovf", 34, 33);
        check("sdiv_ovf_lit", 64'({result_o, flags_o[3]}), 64'({32'h8000_0000, 1'b1}));
        idle(1); issue(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd27, 1'b0, 1); collect("smod_ovf", 34, 33);

        // Stall from acceptance through 5 cycles of FIX: previous result stays on the output
        idle(1);
        issue(3'd0, 32'd10, 32'd20, 1'b0, 5'd2, 1'b1, 1);
        issue(3'd6, 32'd1000, 32'd3, 1'b0, 5'd28, 1'b1, 1);
        stall_i = 1'b1;
        idle(W);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("fix_hold_v", 64'(v_o), 64'(1));
            check("fix_hold_res", 64'(result_o), 64'(32'd30));
            check("fix_hold_stall", 64'(stall_o), 64'(1));
        end
        stall_i = 1'b0;
        drop = sb_q.pop_front();
        idle(1);
        collect("fix_release", 1, 0);
        check("fix_release_stall", 64'(stall_o), 64'(0));

        // Flush at the tenth BUSY cycle discards the division
        idle(1);
        issue(3'd6, 32'd1000, 32'd3, 1'b0, 5'd29, 1'b1, 0);
        idle(9);
        flush_i = 1'b1;
        idle(1);
        flush_i = 1'b0;
        check("flush_busy_v", 64'(v_o), 64'(0));
        check("flush_busy_stall", 64'(stall_o), 64'(0));
        no_result_for("flush_busy_noresult", 40);
        issue(3'd0, 32'd40, 32'd2, 1'b0, 5'd30, 1'b1, 1); collect("post_flush", 1, 0);

        // Reset pulse during BUSY
        idle(1);
        issue(3'd6, 32'd1000, 32'd7, 1'b0, 5'd31, 1'b1, 0);
        idle(5);
        #2 reset = 1'b0;
        #1 check_zero_outputs("reset_busy");
        idle(1);
        reset = 1'b1;
        no_result_for("reset_busy_noresult", 40);
`else
        issue(3'd6, 32'd100, 32'd7, 1'b0, 5'd20, 1'b1, 1); collect("div_stub", 1, 0);
        check("div_stub_lit", 64'({result_o, flags_o}), 64'({32'h0, 4'b1010}));
        issue(3'd7, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd21, 1'b0, 1); collect("mod_stub", 1, 0);

        // Reset pulse while a result is on the output
        issue(3'd0, 32'd5, 32'd6, 1'b0, 5'd22, 1'b1, 0);
        #2 reset = 1'b0;
        #1 check_zero_outputs("reset_mid");
        idle(1);
        reset = 1'b1;
        no_result_for("reset_mid_noresult", 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/execute_multicycle.md
EXECUTE_MULTICYCLE -- requirements
Module: execute_multicycle

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width, legal range 8..64.
REQ-002 SHALL have parameter W_RD, default 5, write-back register index width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports v_i input 1 (op valid); stall_i input 1 (downstream hold); flush_i input 1 (synchronous kill).
REQ-006 SHALL have ports opr0_i input W, opr1_i input W, op_i input 3, signed_i input 1, wb_r_i input W_RD, wb_en_i input 1.
REQ-007 SHALL have ports v_o output 1, stall_o output 1, result_o output W, flags_o output 4 (0 carry, 1 zero, 2 sign, 3 overflow), wb_r_o output W_RD, wb_o output 1.

Function
REQ-008 SHALL decode op_i: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL (low W bits), 6 DIV, 7 MOD.
REQ-009 SHALL define load_en = ~stall_i | ~v_o; output registers (v_o, result_o, flags_o, wb_r_o, wb_en) update only when load_en.
REQ-010 SHALL drive stall_o = ~load_en | (state != IDLE); an op is accepted when v_i & ~stall_o.
REQ-011 SHALL complete ops 0-5 in one cycle: accepted at edge t, v_o=1 with result after edge t.
REQ-012 SHALL compute flags: Z = result==0; N = result[W-1]; C = carry-out (ADD), borrow (SUB), else 0; V = signed overflow (ADD/SUB), high product bits not sign/zero extension of low half (MUL, per signed_i), else 0.
REQ-013 SHALL implement FSM IDLE -> BUSY -> FIX -> IDLE for DIV/MOD: acceptance latches operands, sets counter to W, enters BUSY.
REQ-014 SHALL in BUSY produce one restoring-division quotient bit per cycle on operand magnitudes, decrementing counter; counter 0 -> FIX.
REQ-015 SHALL in FIX apply sign correction (quotient truncates toward zero, remainder takes dividend sign), load output when load_en, return to IDLE; remain in FIX while ~load_en.
REQ-016 SHALL give DIV/MOD latency W+2 edges from acceptance to v_o=1 with stall_i low.
REQ-017 SHALL load v_o=0 on load_en while state is BUSY or when no op accepted.
REQ-018 SHALL on divisor 0 skip BUSY: result all-ones (DIV) or dividend (MOD), V=1, latency 1.
REQ-019 SHALL on signed most-negative / -1 give quotient most-negative, remainder 0, V=1.
REQ-020 SHALL on flush_i clear v_o, return FSM to IDLE, discard in-progress division; flush_i has priority over acceptance in the same cycle.
REQ-021 SHALL drive wb_o = v_o & registered wb_en_i; wb_r_o is registered wb_r_i of the same op.

Reset
REQ-022 SHALL on reset low asynchronously force state IDLE, counter 0, v_o 0, result_o 0, flags_o 0, wb_r_o 0, wb_o 0; stall_o then 0.
REQ-023 SHALL abandon any division when reset asserts mid-operation; no result emitted after release.

Configuration
REQ-024 SHALL with EXEC_ITER_DIV_EN defined include the divider FSM per REQ-013..019.
REQ-025 SHALL without EXEC_ITER_DIV_EN omit FSM/divider; DIV/MOD complete in 1 cycle with result 0, V=1; stall_o = ~load_en.

Verification (W=32)
REQ-026 SHALL cover: ADD 0xFFFFFFFF+1 -> next cycle result 0, flags C=1 Z=1 V=0 N=0.
REQ-027 SHALL cover: signed DIV -7/2 -> v_o after 34 edges, result 0xFFFFFFFD; MOD -> 0xFFFFFFFF; stall_o high 33 cycles.
REQ-028 SHALL cover: DIV 100/0 -> 1 cycle, result 0xFFFFFFFF, V=1; signed 0x80000000/-1 -> 0x80000000, V=1.
REQ-029 SHALL cover: stall_i held high during FIX for 5 cycles -> state FIX held, prior v_o/result stable, DIV result emitted on first cycle stall_i drops.
REQ-030 SHALL cover: flush_i at BUSY cycle 10 -> IDLE next edge, stall_o 0, no DIV result; reset pulse mid-BUSY -> all outputs 0.
